// File: rtl/lsu_pkg.sv
// Shared types and encodings for the load/store unit: FSM states, decoder
// size encodings and the byte-mask helper.
package lsu_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_B0_CMD = 3'd1,
        S_B0_RD  = 3'd2,
        S_B1_CMD = 3'd3,
        S_B1_RD  = 3'd4,
        S_DONE   = 3'd5,
        S_ERR    = 3'd6
    } lsu_state_e;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;

    // Store encodings double as the internal access-size code.
    localparam logic [1:0] SB = 2'b00;
    localparam logic [1:0] SH = 2'b01;
    localparam logic [1:0] SW = 2'b10;

    function automatic logic [3:0] size_mask(input logic [1:0] size);
        case (size)
            SB:      size_mask = 4'b0001;
            SH:      size_mask = 4'b0011;
            default: size_mask = 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic shared by both bus beats: byte enables, store
// rotation and load shift/extension. Beat-1 paths exist only with LSU_MISALIGN_SPLIT_EN.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [1:0]  i_off,
    input  logic [1:0]  i_size,
    input  logic        i_uns,
    input  logic [31:0] i_st_data,
    input  logic [31:0] i_w0,
`ifdef LSU_MISALIGN_SPLIT_EN
    input  logic [31:0] i_w1,
    output logic [3:0]  o_be1,
`endif
    output logic [3:0]  o_be0,
    output logic [31:0] o_wdata,
    output logic [31:0] o_ld_data
);

    logic [5:0]  w_sh;
    logic [31:0] w_ld_raw;

    assign w_sh = {1'b0, i_off, 3'b000};

`ifdef LSU_MISALIGN_SPLIT_EN
    logic [7:0] w_be_wide;
    assign w_be_wide = {4'b0000, size_mask(i_size)} << i_off;
    assign o_be0     = w_be_wide[3:0];
    assign o_be1     = w_be_wide[7:4];
    // Bytes shifted out of beat 0 are refilled from the low lanes of beat 1.
    assign w_ld_raw  = (i_w0 >> w_sh) | (i_w1 << (6'd32 - w_sh));
`else
    assign o_be0     = size_mask(i_size) << i_off;
    assign w_ld_raw  = i_w0 >> w_sh;
`endif

    assign o_wdata = (i_st_data << w_sh) | (i_st_data >> (6'd32 - w_sh));

    always_comb begin
        case (i_size)
            SB:      o_ld_data = {{24{~i_uns & w_ld_raw[7]}}, w_ld_raw[7:0]};
            SH:      o_ld_data = {{16{~i_uns & w_ld_raw[15]}}, w_ld_raw[15:0]};
            default: o_ld_data = w_ld_raw;
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// Multi-cycle load/store unit: one request at a time onto a word-wide bus.
// Define LSU_MISALIGN_SPLIT_EN to split misaligned accesses; otherwise they trap.
module lsu_ctrl
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              mem_wren,
    input  logic [2:0]        l_length,
    input  logic              l_unsigned,
    input  logic [1:0]        s_length,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       st_data,
    output logic [31:0]       ld_data,
    output logic              done,
    output logic              err,
    output logic              bus_valid,
    output logic              bus_we,
    output logic [3:0]        bus_be,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [31:0]       bus_wdata,
    input  logic              bus_ready,
    input  logic              bus_rvalid,
    input  logic [31:0]       bus_rdata,
    output lsu_state_e        o_dbg_state
);

    lsu_state_e        r_state, w_next;
    logic [1:0]        r_size, r_off;
    logic              r_uns, r_we;
    logic              r_bus_valid, r_bus_we;
    logic [3:0]        r_bus_be;
    logic [ADDR_W-1:0] r_bus_addr;
    logic [31:0]       r_bus_wdata, r_ld_data;

    logic [1:0]  w_size, w_size_sel, w_off_sel;
    logic        w_uns, w_illegal, w_misal, w_trap, w_accept, w_split;
    logic [3:0]  w_be0;
    logic [31:0] w_wdata, w_ld, w_w0;

`ifdef LSU_MISALIGN_SPLIT_EN
    logic        r_split;
    logic [31:0] r_w0, w_w1;
    logic [3:0]  w_be1;
    assign w_split = r_split;
    assign w_trap  = w_illegal;
    assign w_w0    = (r_state == S_B1_RD) ? r_w0 : bus_rdata;
    assign w_w1    = (r_state == S_B1_RD) ? bus_rdata : 32'd0;
`else
    assign w_split = 1'b0;
    assign w_trap  = w_illegal | w_misal;
    assign w_w0    = bus_rdata;
`endif

    assign w_accept = req_valid && (r_state == S_IDLE);

    always_comb begin
        w_size    = SW;
        w_uns     = 1'b0;
        w_illegal = 1'b0;
        if (mem_wren) begin
            w_size    = s_length;
            w_illegal = (s_length == 2'b11);
        end else begin
            w_uns = l_unsigned;
            case (l_length)
                LB:      w_size = SB;
                LH:      w_size = SH;
                LW:      w_size = SW;
                LBU:     begin w_size = SB; w_uns = 1'b1; end
                LHU:     begin w_size = SH; w_uns = 1'b1; end
                default: w_illegal = 1'b1;
            endcase
        end
    end

    assign w_misal = ((w_size == SH) && (addr[1:0] == 2'b11)) ||
                     ((w_size == SW) && (addr[1:0] != 2'b00));

    // In IDLE the aligner sees the live request so beat 0 is ready at acceptance.
    assign w_off_sel  = (r_state == S_IDLE) ? addr[1:0] : r_off;
    assign w_size_sel = (r_state == S_IDLE) ? w_size : r_size;

    lsu_align u_align (
        .i_off     (w_off_sel),
        .i_size    (w_size_sel),
        .i_uns     (r_uns),
        .i_st_data (st_data),
        .i_w0      (w_w0),
`ifdef LSU_MISALIGN_SPLIT_EN
        .i_w1      (w_w1),
        .o_be1     (w_be1),
`endif
        .o_be0     (w_be0),
        .o_wdata   (w_wdata),
        .o_ld_data (w_ld)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (w_accept) w_next = w_trap ? S_ERR : S_B0_CMD;
            S_B0_CMD: if (bus_ready) begin
                          if (r_we) w_next = w_split ? S_B1_CMD : S_DONE;
                          else      w_next = S_B0_RD;
                      end
            S_B0_RD:  if (bus_rvalid) w_next = w_split ? S_B1_CMD : S_DONE;
`ifdef LSU_MISALIGN_SPLIT_EN
            S_B1_CMD: if (bus_ready) w_next = r_we ? S_DONE : S_B1_RD;
            S_B1_RD:  if (bus_rvalid) w_next = S_DONE;
`endif
            S_DONE:   w_next = S_IDLE;
            S_ERR:    w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_size      <= SB;
            r_off       <= 2'b00;
            r_uns       <= 1'b0;
            r_we        <= 1'b0;
            r_bus_valid <= 1'b0;
            r_bus_we    <= 1'b0;
            r_bus_be    <= 4'b0000;
            r_bus_addr  <= '0;
            r_bus_wdata <= 32'd0;
            r_ld_data   <= 32'd0;
`ifdef LSU_MISALIGN_SPLIT_EN
            r_split     <= 1'b0;
            r_w0        <= 32'd0;
`endif
        end else begin
            if (w_accept) begin
                r_size <= w_size;
                r_off  <= addr[1:0];
                r_uns  <= w_uns;
                r_we   <= mem_wren;
`ifdef LSU_MISALIGN_SPLIT_EN
                r_split <= w_misal;
`endif
            end
            if (w_accept && !w_trap) begin
                r_bus_valid <= 1'b1;
                r_bus_we    <= mem_wren;
                r_bus_be    <= w_be0;
                r_bus_addr  <= {addr[ADDR_W-1:2], 2'b00};
                r_bus_wdata <= w_wdata;
            end else if (((r_state == S_B0_CMD) || (r_state == S_B1_CMD)) && bus_ready) begin
                r_bus_valid <= 1'b0;
            end
`ifdef LSU_MISALIGN_SPLIT_EN
            // Beat 1 reuses the held write data; only address and enables change.
            if ((w_next == S_B1_CMD) && (r_state != S_B1_CMD)) begin
                r_bus_valid <= 1'b1;
                r_bus_be    <= w_be1;
                r_bus_addr  <= r_bus_addr + ADDR_W'(4);
            end
            if ((r_state == S_B0_RD) && bus_rvalid) r_w0 <= bus_rdata;
`endif
            if (((r_state == S_B0_RD) && bus_rvalid && !w_split) ||
                ((r_state == S_B1_RD) && bus_rvalid))
                r_ld_data <= w_ld;
        end
    end

    assign req_ready   = (r_state == S_IDLE);
    assign done        = (r_state == S_DONE);
    assign err         = (r_state == S_ERR);
    assign bus_valid   = r_bus_valid;
    assign bus_we      = r_bus_we;
    assign bus_be      = r_bus_be;
    assign bus_addr    = r_bus_addr;
    assign bus_wdata   = r_bus_wdata;
    assign ld_data     = r_ld_data;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl; the split-access checks follow LSU_MISALIGN_SPLIT_EN.
module tb_lsu_ctrl;
    import lsu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, mem_wren, l_unsigned;
    logic [2:0]  l_length;
    logic [1:0]  s_length;
    logic [31:0] addr, st_data, ld_data;
    logic        done, err, bus_valid, bus_we, bus_ready, bus_rvalid;
    logic [3:0]  bus_be;
    logic [31:0] bus_addr, bus_wdata, bus_rdata;
    lsu_state_e  dbg_state;

    int tests  = 0;
    int fails  = 0;
    int n_done = 0;
    logic [31:0] exp_q[$];

    lsu_ctrl #(.ADDR_W(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .mem_wren    (mem_wren),
        .l_length    (l_length),
        .l_unsigned  (l_unsigned),
        .s_length    (s_length),
        .addr        (addr),
        .st_data     (st_data),
        .ld_data     (ld_data),
        .done        (done),
        .err         (err),
        .bus_valid   (bus_valid),
        .bus_we      (bus_we),
        .bus_be      (bus_be),
        .bus_addr    (bus_addr),
        .bus_wdata   (bus_wdata),
        .bus_ready   (bus_ready),
        .bus_rvalid  (bus_rvalid),
        .bus_rdata   (bus_rdata),
        .o_dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (done) n_done++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic we, input logic [2:0] ll, input logic lu,
                         input logic [1:0] sl, input logic [31:0] a, input logic [31:0] d);
        mem_wren   = we;
        l_length   = ll;
        l_unsigned = lu;
        s_length   = sl;
        addr       = a;
        st_data    = d;
        req_valid  = 1'b1;
        tick;
        req_valid  = 1'b0;
    endtask

    task automatic aligned_load(input string tag, input logic [2:0] ll, input logic lu,
                                input logic [31:0] a, input logic [31:0] rdata,
                                input logic [31:0] e_addr, input logic [3:0] e_be,
                                input logic [31:0] e_ld);
        logic [31:0] e;
        exp_q.push_back(e_ld);
        issue(1'b0, ll, lu, 2'b00, a, 32'd0);
        chk({tag, " bus_valid"}, bus_valid, 1);
        chk({tag, " bus_addr"}, bus_addr, e_addr);
        chk({tag, " bus_be"}, bus_be, e_be);
        chk({tag, " bus_we"}, bus_we, 0);
        chk({tag, " req_ready busy"}, req_ready, 0);
        bus_ready = 1'b1;
        tick;
        bus_ready = 1'b0;
        chk({tag, " bus_valid drop"}, bus_valid, 0);
        chk({tag, " early done"}, done, 0);
        bus_rvalid = 1'b1;
        bus_rdata  = rdata;
        tick;
        bus_rvalid = 1'b0;
        e = exp_q.pop_front();
        chk({tag, " done"}, done, 1);
        chk({tag, " ld_data"}, ld_data, e);
        tick;
        chk({tag, " done pulse"}, done, 0);
        chk({tag, " req_ready back"}, req_ready, 1);
    endtask

    task automatic aligned_store(input string tag, input logic [1:0] sl, input logic [31:0] a,
                                 input logic [31:0] d, input logic [31:0] e_addr,
                                 input logic [3:0] e_be, input logic [31:0] e_wdata);
        issue(1'b1, 3'b000, 1'b0, sl, a, d);
        chk({tag, " bus_valid"}, bus_valid, 1);
        chk({tag, " bus_addr"}, bus_addr, e_addr);
        chk({tag, " bus_be"}, bus_be, e_be);
        chk({tag, " bus_wdata"}, bus_wdata, e_wdata);
        chk({tag, " bus_we"}, bus_we, 1);
        bus_ready = 1'b1;
        tick;
        bus_ready = 1'b0;
        chk({tag, " done"}, done, 1);
        chk({tag, " bus_valid drop"}, bus_valid, 0);
        tick;
        chk({tag, " req_ready back"}, req_ready, 1);
    endtask

    task automatic err_req(input string tag, input logic we, input logic [2:0] ll,
                           input logic [1:0] sl, input logic [31:0] a);
        issue(we, ll, 1'b0, sl, a, 32'h1234_5678);
        chk({tag, " err"}, err, 1);
        chk({tag, " done"}, done, 0);
        chk({tag, " bus_valid"}, bus_valid, 0);
        chk({tag, " req_ready"}, req_ready, 0);
        tick;
        chk({tag, " err pulse"}, err, 0);
        chk({tag, " req_ready back"}, req_ready, 1);
        chk({tag, " bus_valid idle"}, bus_valid, 0);
    endtask

    initial begin
        int n0;
        rst        = 1'b1;
        req_valid  = 1'b0;
        mem_wren   = 1'b0;
        l_length   = 3'b000;
        l_unsigned = 1'b0;
        s_length   = 2'b00;
        addr       = 32'd0;
        st_data    = 32'd0;
        bus_ready  = 1'b0;
        bus_rvalid = 1'b0;
        bus_rdata  = 32'd0;

        // Reset state
        tick;
        tick;
        chk("rst state", 32'(dbg_state), 32'(S_IDLE));
        chk("rst req_ready", req_ready, 1);
        chk("rst bus_valid", bus_valid, 0);
        chk("rst bus_we", bus_we, 0);
        chk("rst bus_be", bus_be, 0);
        chk("rst done", done, 0);
        chk("rst err", err, 0);
        chk("rst bus_addr", bus_addr, 0);
        chk("rst bus_wdata", bus_wdata, 0);
        chk("rst ld_data", ld_data, 0);
        rst = 1'b0;
        tick;

        // Aligned loads with lane selection and extension
        aligned_load("lw 100", LW, 1'b0, 32'h100, 32'hDEADBEEF, 32'h100, 4'b1111, 32'hDEADBEEF);
        aligned_load("lb 103", LB, 1'b0, 32'h103, 32'h80FFFFFF, 32'h100, 4'b1000, 32'hFFFFFF80);
        aligned_load("lbu 103", LBU, 1'b0, 32'h103, 32'h80FFFFFF, 32'h100, 4'b1000, 32'h00000080);
        aligned_load("lh 102", LH, 1'b0, 32'h102, 32'h80011234, 32'h100, 4'b1100, 32'hFFFF8001);
        aligned_load("lh uns 102", LH, 1'b1, 32'h102, 32'h80011234, 32'h100, 4'b1100, 32'h00008001);
        aligned_load("lb 001", LB, 1'b0, 32'h001, 32'h11227F44, 32'h000, 4'b0010, 32'h0000007F);

        // Aligned stores with lane rotation
        aligned_store("sh 202", SH, 32'h202, 32'h0000ABCD, 32'h200, 4'b1100, 32'hABCD0000);
        aligned_store("sb 101", SB, 32'h101, 32'h12345678, 32'h100, 4'b0010, 32'h34567812);
        aligned_store("sw 300", SW, 32'h300, 32'hCAFEF00D, 32'h300, 4'b1111, 32'hCAFEF00D);

        // Illegal sizes
        err_req("s_length 11", 1'b1, 3'b000, 2'b11, 32'h40);
        err_req("l_length 111", 1'b0, 3'b111, 2'b00, 32'h40);
        err_req("l_length 011", 1'b0, 3'b011, 2'b00, 32'h40);

`ifdef LSU_MISALIGN_SPLIT_EN
        // Split load across the top of the address space
        issue(1'b0, LW, 1'b0, 2'b00, 32'hFFFFFFFE, 32'd0);
        chk("split ld b0 valid", bus_valid, 1);
        chk("split ld b0 addr", bus_addr, 32'hFFFFFFFC);
        chk("split ld b0 be", bus_be, 4'b1100);
        bus_ready = 1'b1;
        tick;
        bus_ready = 1'b0;
        chk("split ld b0 drop", bus_valid, 0);
        bus_rvalid = 1'b1;
        bus_rdata  = 32'h3344AAAA;
        tick;
        bus_rvalid = 1'b0;
        chk("split ld b1 valid", bus_valid, 1);
        chk("split ld b1 addr", bus_addr, 32'h00000000);
        chk("split ld b1 be", bus_be, 4'b0011);
        chk("split ld no early done", done, 0);
        bus_ready = 1'b1;
        tick;
        bus_ready = 1'b0;
        chk("split ld b1 drop", bus_valid, 0);
        bus_rvalid = 1'b1;
        bus_rdata  = 32'hBBBB1122;
        tick;
        bus_rvalid = 1'b0;
        chk("split ld done", done, 1);
        chk("split ld data", ld_data, 32'h11223344);
        tick;
        chk("split ld idle", req_ready, 1);

        // Split store: second beat follows the first without a gap
        issue(1'b1, 3'b000, 1'b0, SW, 32'h201, 32'h11223344);
        chk("split st b0 addr", bus_addr, 32'h200);
        chk("split st b0 be", bus_be, 4'b1110);
        chk("split st b0 wdata", bus_wdata, 32'h22334411);
        bus_ready = 1'b1;
        tick;
        chk("split st b1 valid", bus_valid, 1);
        chk("split st b1 addr", bus_addr, 32'h204);
        chk("split st b1 be", bus_be, 4'b0001);
        chk("split st b1 wdata", bus_wdata, 32'h22334411);
        tick;
        bus_ready = 1'b0;
        chk("split st done", done, 1);
        chk("split st drop", bus_valid, 0);
        tick;
`else
        err_req("misaligned lw", 1'b0, LW, 2'b00, 32'hFFFFFFFE);
        err_req("misaligned sh", 1'b1, 3'b000, SH, 32'h203);
`endif

        // Stalled command is held stable; rvalid outside a read state is ignored
        issue(1'b0, LW, 1'b0, 2'b00, 32'h400, 32'd0);
        bus_rvalid = 1'b1;
        bus_rdata  = 32'h5555AAAA;
        for (int i = 0; i < 3; i++) begin
            tick;
            chk("stall valid", bus_valid, 1);
            chk("stall addr", bus_addr, 32'h400);
            chk("stall state", 32'(dbg_state), 32'(S_B0_CMD));
        end
        bus_rvalid = 1'b0;
        bus_ready  = 1'b1;
        tick;
        bus_ready  = 1'b0;
        chk("stall now reading", 32'(dbg_state), 32'(S_B0_RD));

        // Reset in the read phase with read data pending
        n0         = n_done;
        bus_rvalid = 1'b1;
        rst        = 1'b1;
        #1;
        chk("abort valid", bus_valid, 0);
        chk("abort req_ready", req_ready, 1);
        tick;
        rst = 1'b0;
        tick;
        tick;
        bus_rvalid = 1'b0;
        chk("abort no done", n_done, n0);
        chk("abort state", 32'(dbg_state), 32'(S_IDLE));

        // Reset during a command drops bus_valid without waiting for a clock
        issue(1'b1, 3'b000, 1'b0, SW, 32'h500, 32'h0BADF00D);
        chk("cmd abort pre", bus_valid, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("cmd abort async", bus_valid, 0);
        tick;
        rst = 1'b0;
        tick;

        aligned_load("post rst lw", LW, 1'b0, 32'h100, 32'h0F1E2D3C, 32'h100, 4'b1111, 32'h0F1E2D3C);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
